// File: rtl/add_sub_16_seq_if.sv
// Request/response bundle for the nibble-serial 16-bit add/subtract unit.
// The master issues operands; the slave returns status and result.
interface add_sub_16_seq_if;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] r;
  logic        cout;
  logic        ovf;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, r, cout, ovf
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, r, cout, ovf
  );
endinterface

// File: rtl/add_sub_16_seq.sv
// Nibble-serial 16-bit adder/subtractor: one 4-bit slice per cycle,
// result published only once all four nibbles are complete.
module add_sub_16_seq (
  input  logic             clk,
  input  logic             rst,
  add_sub_16_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        op_q, op_d;
  logic [11:0] acc_q, acc_d;
  logic [15:0] r_q, r_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic        cin;
  logic [3:0]  lo;
  logic [1:0]  hi;
  logic [3:0]  nib;

  // Slice: low 3 bits first so the carry into the nibble MSB is visible.
  always_comb begin
    a_nib = a_q[{idx_q, 2'b00} +: 4];
    b_nib = b_q[{idx_q, 2'b00} +: 4] ^ {4{op_q}};
    cin   = (idx_q == 2'd0) ? op_q : carry_q;
    lo    = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, cin};
    hi    = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, lo[3]};
    nib   = {hi[0], lo[2:0]};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    r_d     = r_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          idx_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = hi[1];
        idx_d   = idx_q + 2'd1;
        unique case (idx_q)
          2'd0: acc_d[3:0]  = nib;
          2'd1: acc_d[7:4]  = nib;
          2'd2: acc_d[11:8] = nib;
          2'd3: begin
            r_d     = {nib, acc_q};
            cout_d  = hi[1];
            ovf_d   = hi[1] ^ lo[3];
            state_d = DONE;
          end
        endcase
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      r_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == RUN) || (state_q == DONE);
  assign bus.done  = (state_q == DONE);
  assign bus.r     = r_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_add_sub_16_seq.sv
// Directed bench for add_sub_16_seq with a result scoreboard.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_add_sub_16_seq;

  typedef struct packed {
    logic [15:0] r;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  add_sub_16_seq_if bus ();

  add_sub_16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t last_exp;
  int   n_done = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic op);
    logic [15:0] bx;
    logic [16:0] s;
    exp_t e;
    bx     = op ? ~b : b;
    s      = {1'b0, a} + {1'b0, bx} + {16'd0, op};
    e.r    = s[15:0];
    e.cout = s[16];
    e.ovf  = (a[15] == bx[15]) && (s[15] != a[15]);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest request.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        last_exp = sb.pop_front();
        check("sb_r", {16'd0, bus.r}, {16'd0, last_exp.r});
        check("sb_cout", {31'd0, bus.cout}, {31'd0, last_exp.cout});
        check("sb_ovf", {31'd0, bus.ovf}, {31'd0, last_exp.ovf});
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic op);
    exp_t e;
    wait_ready(tag);
    e = model(a, b, op);
    bus.a     = a;
    bus.b     = b;
    bus.op    = op;
    bus.start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.op    = 1'($urandom);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_early"}, {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    check({tag, "_hold_r"}, {16'd0, bus.r}, {16'd0, e.r});
    check({tag, "_hold_cout"}, {31'd0, bus.cout}, {31'd0, e.cout});
    check({tag, "_hold_ovf"}, {31'd0, bus.ovf}, {31'd0, e.ovf});
  endtask

  initial begin
    int   k0;
    int   d[$];
    exp_t e;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = 16'd0;
    bus.b     = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_r", {16'd0, bus.r}, 32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add", 16'h1234, 16'h0FFF, 1'b0);
    check("add_r_lit", {16'd0, bus.r}, 32'h2233);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0);
    check("add_wrap_cout_lit", {31'd0, bus.cout}, 32'd1);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
    check("add_ovf_lit", {31'd0, bus.ovf}, 32'd1);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1);
    check("sub_neg_r_lit", {16'd0, bus.r}, 32'hFFFE);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1);
    check("sub_ovf_r_lit", {16'd0, bus.r}, 32'h7FFF);
    run_op("sub_zero", 16'h1234, 16'h1234, 1'b1);
    check("sub_zero_cout_lit", {31'd0, bus.cout}, 32'd1);
    for (int i = 0; i < 4; i++)
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom));

    // Start while busy must be ignored.
    wait_ready("busy_start");
    bus.a = 16'h1234; bus.b = 16'h0FFF; bus.op = 1'b0; bus.start = 1'b1;
    sb.push_back(model(16'h1234, 16'h0FFF, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.op = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start_ready2", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    check("busy_start_ready3", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    check("busy_start_done", {31'd0, bus.done}, 32'd1);
    check("busy_start_r", {16'd0, bus.r}, 32'h2233);
    @(negedge clk);
    check("busy_start_ready", {31'd0, bus.ready}, 32'd1);
    repeat (6) @(negedge clk);
    check("busy_start_idle", {31'd0, bus.busy}, 32'd0);

    // Reset during nibble 2 aborts without a done pulse.
    bus.a = 16'h4321; bus.b = 16'h1111; bus.op = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k0 = n_done;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_r", {16'd0, bus.r}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_no_done", n_done, k0);
    run_op("post_abort", 16'h00FF, 16'h0001, 1'b0);
    check("post_abort_r_lit", {16'd0, bus.r}, 32'h0100);

    // Start held high: three back-to-back operations.
    wait_ready("held");
    e = model(16'hBEEF, 16'h1357, 1'b1);
    bus.a = 16'hBEEF; bus.b = 16'h1357; bus.op = 1'b1; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(e);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 13) bus.start = 1'b0;
      if (bus.done === 1'b1) d.push_back(c);
    end
    check("held_count", d.size(), 32'd3);
    if (d.size() == 3) begin
      check("held_first", d[0], 32'd5);
      check("held_gap1", d[1] - d[0], 32'd6);
      check("held_gap2", d[2] - d[1], 32'd6);
    end
    check("held_r", {16'd0, bus.r}, {16'd0, e.r});
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_sub_16_seq.md
ADD_SUB_16_SEQ -- requirements
Module: add_sub_16_seq

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits, processed as four 4-bit nibbles.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start.
REQ-006 a  input  16  operand A; captured with start.
REQ-007 b  input  16  operand B; captured with start.
REQ-008 ready  output  1  high exactly when state is IDLE.
REQ-009 busy  output  1  high when state is RUN or DONE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 r  output  16  result of the last completed operation.
REQ-012 cout  output  1  carry out of bit 15; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  signed two's-complement overflow of the last completed operation.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 at an edge SHALL latch a, b and op, clear the nibble index to 0, and move the FSM to RUN; start=0 SHALL leave the FSM in IDLE.
REQ-016 RUN: each edge SHALL compute exactly one nibble i (bits 4i+3..4i) with a single 4-bit full-adder slice, then increment i.
REQ-017 Slice operands SHALL be a_nib and (b_nib XOR {4{op}}); carry-in SHALL be op for nibble 0 and the registered carry from nibble i-1 for nibbles 1..3.
REQ-018 The nibble-3 edge SHALL write the assembled 16-bit sum to r, slice carry-out to cout, and (carry into bit 15 XOR carry out of bit 15) to ovf, then move the FSM to DONE.
REQ-019 DONE SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge.
REQ-020 Latency: with start sampled at edge k, r, cout and ovf SHALL update at edge k+4, done SHALL be high between edges k+4 and k+5, and ready SHALL be high again after edge k+5.
REQ-021 r, cout and ovf SHALL hold their values from completion until the next completion or reset; partial results SHALL never appear on r.
REQ-022 start SHALL be ignored in RUN and DONE; a start held high through DONE SHALL be accepted at the first edge back in IDLE, giving back-to-back throughput of one operation per 6 cycles.
REQ-023 Changes on a, b or op after capture SHALL NOT affect the operation in progress.
REQ-024 Arithmetic SHALL be modulo 2^16; no saturation.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, nibble index 0, carry register 0, r=0x0000, cout=0, ovf=0 and done=0, and SHALL discard any captured operands; after that edge, ready=1 and busy=0.
REQ-026 rst SHALL take priority over start, and a reset asserted in RUN or DONE SHALL abort the operation with no done pulse.

Verification
REQ-027 Add: a=0x1234, b=0x0FFF, op=0, start pulse -> done high exactly 4 edges after capture; r=0x2233, cout=0, ovf=0.
REQ-028 Add wrap-around: 0xFFFF+0x0001 -> r=0x0000, cout=1, ovf=0; 0x7FFF+0x0001 -> r=0x8000, cout=0, ovf=1.
REQ-029 Subtract: 0x0005-0x0007 -> r=0xFFFE, cout=0; 0x8000-0x0001 -> r=0x7FFF, cout=1, ovf=1; 0x1234-0x1234 -> r=0x0000, cout=1, ovf=0.
REQ-030 Busy-time start: start pulsed with new operands 2 cycles after capture -> request ignored; first result unchanged; ready stays 0 until after DONE.
REQ-031 Reset mid-op: rst asserted for 1 cycle during RUN nibble 2 -> no done pulse; r=0x0000, ready=1 next cycle; a following 0x00FF+0x0001 yields r=0x0100.
REQ-032 Held start: start tied high for 3 operations with fixed operands -> done pulses exactly 6 cycles apart, identical results each time.
